// File: rtl/ff_arb_pkg.sv
// ff_arb_pkg: shared types and width helpers for the flip-flop bank arbiter
package ff_arb_pkg;
  typedef enum logic {ARB, LOCKED} arb_state_e;
  localparam int DEF_N_REQ = 4;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_MAX_BURST = 4;
  function automatic int idx_w(int n);
    return $clog2(n);
  endfunction
  function automatic int cnt_w(int m);
    return $clog2(m + 1);
  endfunction
  localparam int IDX_W = idx_w(DEF_N_REQ);
  localparam int CNT_W = cnt_w(DEF_MAX_BURST);
endpackage

// File: rtl/ff_bank_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first set bit of eligible starting at ptr
module rr_pick
  import ff_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ
) (
  input  logic [N_REQ-1:0]        eligible,
  input  logic [idx_w(N_REQ)-1:0] ptr,
  output logic                    valid,
  output logic [idx_w(N_REQ)-1:0] idx
);
  localparam int IW = idx_w(N_REQ);
  // scan from the farthest offset back toward ptr so the nearest eligible requester wins
  always_comb begin
    int j;
    valid = |eligible;
    idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      j = (j >= N_REQ) ? j - N_REQ : j;
      if (eligible[j]) idx = IW'(j);
    end
  end
endmodule

// File: rtl/ff_bank_arbiter.sv
// ff_bank_arbiter: round-robin arbiter loading one requester's data per cycle into a shared register bank
module ff_bank_arbiter
  import ff_arb_pkg::*;
#(
  parameter int N_REQ     = DEF_N_REQ,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                      clk,
  input  logic                      async_reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          lock,
  input  logic [N_REQ*DATA_W-1:0]   wdata,
  output logic [N_REQ-1:0]          gnt,
  output logic [DATA_W-1:0]         q,
  output logic                      q_valid,
  output logic [idx_w(N_REQ)-1:0]   owner,
  output logic                      locked
);
  localparam int IW = idx_w(N_REQ);
  localparam int CW = cnt_w(MAX_BURST);
  arb_state_e state;
  logic [IW-1:0] ptr, win, nxt_win, nxt_own;
  logic [CW-1:0] burst_cnt;
  logic [N_REQ-1:0] eligible;
  logic win_v, last_beat;
  // the requester granted last cycle sits out one cycle so each request gets one grant
  assign eligible = req & ~gnt;
  assign nxt_win = (win == IW'(N_REQ - 1)) ? '0 : win + 1'b1;
  assign nxt_own = (owner == IW'(N_REQ - 1)) ? '0 : owner + 1'b1;
  assign last_beat = !lock[owner] || (int'(burst_cnt) + 1 == MAX_BURST);
  assign locked = (state == LOCKED);
  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .eligible (eligible),
    .ptr      (ptr),
    .valid    (win_v),
    .idx      (win)
  );
  // arbitration FSM: one write per cycle, locked owner keeps the bank for a bounded burst
  always_ff @(posedge clk or negedge async_reset) begin
    if (!async_reset) begin
      state <= ARB;
      ptr <= '0;
      burst_cnt <= '0;
      gnt <= '0;
      q <= '0;
      q_valid <= 1'b0;
      owner <= '0;
    end else if (state == ARB) begin
      if (win_v) begin
        gnt <= N_REQ'(1) << win;
        q <= wdata[int'(win)*DATA_W +: DATA_W];
        q_valid <= 1'b1;
        owner <= win;
        if (lock[win] && MAX_BURST > 1) begin
          state <= LOCKED;
          burst_cnt <= CW'(1);
        end else begin
          ptr <= nxt_win;
        end
      end else begin
        gnt <= '0;
        q_valid <= 1'b0;
      end
    end else if (req[owner]) begin
      gnt <= N_REQ'(1) << owner;
      q <= wdata[int'(owner)*DATA_W +: DATA_W];
      q_valid <= 1'b1;
      burst_cnt <= last_beat ? '0 : burst_cnt + 1'b1;
      if (last_beat) begin
        state <= ARB;
        ptr <= nxt_own;
      end
    end else begin
      gnt <= '0;
      q_valid <= 1'b0;
      state <= ARB;
      ptr <= nxt_own;
      burst_cnt <= '0;
    end
  end
endmodule

// File: tb/tb_ff_bank_arbiter.sv
// tb_ff_bank_arbiter: directed and random checks of ff_bank_arbiter against a tenure-level model
module tb_ff_bank_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  localparam int MB = 4;
  logic clk = 1'b0;
  logic async_reset;
  logic [N-1:0] req, lock;
  logic [N*W-1:0] wdata;
  logic [N-1:0] gnt;
  logic [W-1:0] q;
  logic q_valid;
  logic [1:0] owner;
  logic locked;
  int n_tests = 0;
  int n_fail = 0;
  int m_gnt, m_ptr, m_owner, m_beats;
  bit m_locked, m_qv;
  logic [W-1:0] m_q;
  ff_bank_arbiter #(.N_REQ(N), .DATA_W(W), .MAX_BURST(MB)) dut (
    .clk         (clk),
    .async_reset (async_reset),
    .req         (req),
    .lock        (lock),
    .wdata       (wdata),
    .gnt         (gnt),
    .q           (q),
    .q_valid     (q_valid),
    .owner       (owner),
    .locked      (locked)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [W-1:0] wd(input int i);
    return wdata[i*W +: W];
  endfunction
  task automatic model_reset();
    m_gnt = -1;
    m_ptr = 0;
    m_owner = 0;
    m_beats = 0;
    m_locked = 0;
    m_qv = 0;
    m_q = '0;
  endtask
  task automatic model_step();
    int w;
    if (!m_locked) begin
      w = -1;
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (w < 0 && req[j] && j != m_gnt) w = j;
      end
      if (w >= 0) begin
        m_gnt = w;
        m_q = wd(w);
        m_qv = 1;
        m_owner = w;
        if (lock[w] && MB > 1) begin
          m_locked = 1;
          m_beats = 1;
        end else m_ptr = (w + 1) % N;
      end else begin
        m_gnt = -1;
        m_qv = 0;
      end
    end else if (req[m_owner]) begin
      m_gnt = m_owner;
      m_q = wd(m_owner);
      m_qv = 1;
      m_beats++;
      if (!lock[m_owner] || m_beats == MB) begin
        m_locked = 0;
        m_beats = 0;
        m_ptr = (m_owner + 1) % N;
      end
    end else begin
      m_gnt = -1;
      m_qv = 0;
      m_locked = 0;
      m_beats = 0;
      m_ptr = (m_owner + 1) % N;
    end
  endtask
  task automatic check_all(input string tag);
    check({tag, ".gnt"}, 32'(gnt), (m_gnt < 0) ? 32'd0 : 32'd1 << m_gnt);
    check({tag, ".q"}, 32'(q), 32'(m_q));
    check({tag, ".q_valid"}, 32'(q_valid), 32'(m_qv));
    check({tag, ".owner"}, 32'(owner), 32'(m_owner));
    check({tag, ".locked"}, 32'(locked), 32'(m_locked));
  endtask
  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask
  initial begin
    int cnt [N];
    int run, best;
    async_reset = 1'b0;
    req = 4'hF;
    lock = '0;
    wdata = {8'h44, 8'h33, 8'h22, 8'h11};
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    #2;
    async_reset = 1'b1;
    #1;
    check_all("release");
    for (int i = 0; i < N; i++) cnt[i] = 0;
    for (int c = 0; c < 8; c++) begin
      tick("rr");
      for (int i = 0; i < N; i++) cnt[i] += int'(gnt[i]);
    end
    for (int i = 0; i < N; i++) check($sformatf("rr_count%0d", i), 32'(cnt[i]), 32'd2);
    req = '0;
    repeat (2) tick("idle");
    req = 4'b0100;
    wdata[2*W +: W] = 8'hA5;
    repeat (6) tick("single");
    req = 4'b1010;
    lock = 4'b0010;
    run = 0;
    best = 0;
    for (int c = 0; c < 12; c++) begin
      tick("burst");
      run = (gnt == 4'b0010) ? run + 1 : 0;
      best = (run > best) ? run : best;
    end
    check("burst_len", 32'(best), 32'(MB));
    req = '0;
    lock = '0;
    repeat (2) tick("drain");
    req = 4'b0010;
    lock = 4'b0010;
    tick("unlock_b1");
    lock = '0;
    tick("unlock_last");
    tick("unlock_arb");
    req = '0;
    tick("gap");
    req = 4'b0010;
    lock = 4'b0010;
    tick("abort_b1");
    req = '0;
    tick("abort_drop");
    req = 4'b0010;
    tick("rst_b1");
    tick("rst_b2");
    async_reset = 1'b0;
    #1;
    model_reset();
    check_all("mid_burst_reset");
    @(negedge clk);
    #2;
    async_reset = 1'b1;
    req = 4'b1000;
    lock = '0;
    tick("wrap_3");
    req = 4'b1001;
    tick("wrap_0");
    check("wrap_first", 32'(gnt), 32'b0001);
    for (int c = 0; c < 400; c++) begin
      req = N'($urandom);
      lock = ($urandom_range(0, 2) == 0) ? '0 : N'($urandom);
      wdata = {$urandom};
      tick("rand");
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
